// File: rtl/dcache_pkg.sv
// dcache_pkg
//   Shared definitions for the data-cache controller:
//   - state_t      : controller state encoding
//   - POLICY_WT/WB : values of the WB_MODE parameter
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE_BACK = 3'd1,
    FILL       = 3'd2,
    RETRY      = 3'd3,
    WT_WRITE   = 3'd4
  } state_t;

  localparam logic POLICY_WT = 1'b0;
  localparam logic POLICY_WB = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   CLK   in  clock, rising edge
//   RST_N in  asynchronous active-low reset (count -> 0)
//   inc   in  count one event this cycle
//   count out current count (W bits)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/dcache_ctrl_fsm.sv
// dcache_ctrl_fsm
//   Data-cache controller between the CPU memory stage and main memory.
//   Handles hits in IDLE, evicts dirty lines (write-back mode), refills
//   lines word by word over a req/ack handshake, and writes stores through
//   to memory in write-through mode. Counts hits and misses.
// Ports:
//   CLK, RST_N            clock / asynchronous active-low reset
//   cpu_rd, cpu_wr        CPU load/store request (held while stall=1)
//   hit, dirty            tag-match and victim-dirty status
//   mem_ack               memory completed one word this cycle
//   stall                 freeze the pipeline
//   mem_req, mem_we       memory request and direction (1 = write)
//   word_idx              beat index into the line
//   writeback             victim data onto the memory write bus
//   load                  write returned memory word into the cache
//   cache_we              write CPU store data into the cache
//   set_dirty, clr_dirty, set_valid   line status update pulses
//   hit_cnt, miss_cnt     saturating performance counters
module dcache_ctrl_fsm
  import dcache_pkg::*;
#(
  parameter int   WORDS_PER_LINE = 4,
  parameter logic WB_MODE        = POLICY_WB,
  parameter int   CNT_W          = 16
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              cpu_rd,
  input  logic                              cpu_wr,
  input  logic                              hit,
  input  logic                              dirty,
  input  logic                              mem_ack,
  output logic                              stall,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [$clog2(WORDS_PER_LINE)-1:0] word_idx,
  output logic                              writeback,
  output logic                              load,
  output logic                              cache_we,
  output logic                              set_dirty,
  output logic                              clr_dirty,
  output logic                              set_valid,
  output logic [CNT_W-1:0]                  hit_cnt,
  output logic [CNT_W-1:0]                  miss_cnt
);

  localparam int             IDX_W    = $clog2(WORDS_PER_LINE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic           IS_WB    = (WB_MODE == POLICY_WB);

  state_t           r_state;
  logic [IDX_W-1:0] r_word_idx;
  logic             r_after_retry;

  state_t           w_state_next;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_after_retry_next;

  logic w_req, w_is_wr, w_last;
  logic w_stall, w_mem_req, w_mem_we, w_writeback, w_load;
  logic w_cache_we, w_set_dirty, w_clr_dirty, w_set_valid;
  logic w_hit_inc, w_miss_inc;

  // Simultaneous rd and wr is treated as a load.
  assign w_req   = cpu_rd | cpu_wr;
  assign w_is_wr = cpu_wr & ~cpu_rd;
  assign w_last  = (r_word_idx == LAST_IDX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= IDLE;
      r_word_idx    <= '0;
      r_after_retry <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_word_idx    <= w_idx_next;
      r_after_retry <= w_after_retry_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_word_idx;
    w_after_retry_next = r_after_retry;
    w_stall            = 1'b0;
    w_mem_req          = 1'b0;
    w_mem_we           = 1'b0;
    w_writeback        = 1'b0;
    w_load             = 1'b0;
    w_cache_we         = 1'b0;
    w_set_dirty        = 1'b0;
    w_clr_dirty        = 1'b0;
    w_set_valid        = 1'b0;
    w_hit_inc          = 1'b0;
    w_miss_inc         = 1'b0;

    case (r_state)
      IDLE: begin
        w_after_retry_next = 1'b0;
        if (w_req) begin
          if (hit) begin
            // The replayed access after a refill is not a new hit.
            w_hit_inc = ~r_after_retry;
            if (w_is_wr) begin
              w_cache_we = 1'b1;
              if (IS_WB) begin
                w_set_dirty = 1'b1;
              end else begin
                w_stall      = 1'b1;
                w_state_next = WT_WRITE;
              end
            end
          end else begin
            w_stall    = 1'b1;
            w_miss_inc = 1'b1;
            if (IS_WB && dirty) w_state_next = WRITE_BACK;
            else                w_state_next = FILL;
          end
        end
      end

      WRITE_BACK: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_writeback = 1'b1;
        w_stall     = 1'b1;
        if (mem_ack) begin
          w_idx_next = r_word_idx + IDX_W'(1);
          if (w_last) begin
            w_idx_next   = '0;
            w_clr_dirty  = 1'b1;
            w_state_next = FILL;
          end
        end
      end

      FILL: begin
        w_mem_req = 1'b1;
        w_stall   = 1'b1;
        w_load    = mem_ack;
        if (mem_ack) begin
          w_idx_next = r_word_idx + IDX_W'(1);
          if (w_last) begin
            w_idx_next   = '0;
            w_set_valid  = 1'b1;
            w_clr_dirty  = 1'b1;
            w_state_next = RETRY;
          end
        end
      end

      RETRY: begin
        w_stall            = 1'b1;
        w_after_retry_next = 1'b1;
        w_state_next       = IDLE;
      end

      WT_WRITE: begin
        w_mem_req  = 1'b1;
        w_mem_we   = 1'b1;
        w_idx_next = '0;
        // The CPU moves on in the ack cycle itself.
        w_stall    = ~mem_ack;
        if (mem_ack) w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // While reset is asserted the Mealy terms must not leak through from
  // whatever the CPU is still presenting, so every strobe is forced low.
  assign stall     = w_stall     & RST_N;
  assign mem_req   = w_mem_req   & RST_N;
  assign mem_we    = w_mem_we    & RST_N;
  assign writeback = w_writeback & RST_N;
  assign load      = w_load      & RST_N;
  assign cache_we  = w_cache_we  & RST_N;
  assign set_dirty = w_set_dirty & RST_N;
  assign clr_dirty = w_clr_dirty & RST_N;
  assign set_valid = w_set_valid & RST_N;
  assign word_idx  = r_word_idx;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (w_hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (w_miss_inc),
    .count (miss_cnt)
  );

endmodule

// File: doc/dcache_ctrl_fsm.md
Name: dcache_ctrl_fsm

Overview:
- Parametrised data-cache controller FSM; successor to the fixed 4-beat controller.
- Sits between the CPU memory stage and main memory. Drives the pipeline stall, the cache array update strobes, and a word-by-word req/ack memory handshake.
- Adds a configurable line length, a write-back or write-through policy, a real beat counter, and saturating hit/miss performance counters.

Parameters:
- WORDS_PER_LINE, 4, beats per line transfer; power of 2, 2..16.
- WB_MODE, 1, 1 = write-back/write-allocate, 0 = write-through/write-allocate.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  load request, held until stall is low.
- cpu_wr  in  1  store request, held until stall is low.
- hit  in  1  tag match and valid for the current address.
- dirty  in  1  victim line dirty bit.
- mem_ack  in  1  memory accepted/returned one word this cycle.
- stall  out  1  freeze the pipeline.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = memory write, 0 = memory read.
- word_idx  out  $clog2(WORDS_PER_LINE)  beat index into the line.
- writeback  out  1  select victim line data onto the memory write bus.
- load  out  1  write the returned memory word into the cache at word_idx.
- cache_we  out  1  write CPU store data into the cache (hit).
- set_dirty  out  1  one-cycle pulse.
- clr_dirty  out  1  one-cycle pulse.
- set_valid  out  1  one-cycle pulse.
- hit_cnt  out  CNT_W  saturating count of hits.
- miss_cnt  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, word_idx=0, hit_cnt=0, miss_cnt=0, after_retry=0. All strobe outputs 0 immediately.
- Reset mid-transfer aborts: mem_req drops asynchronously, no clr_dirty/set_valid pulse, the line is left as-is.
- req = cpu_rd | cpu_wr. If both are high, the access is treated as a read (rd priority).
- States: IDLE, WRITE_BACK, FILL, RETRY, WT_WRITE. Strobes not listed for a state are 0.
- IDLE, no req: all outputs 0, stay.
- IDLE, req & hit, read: stall=0, stay.
- IDLE, req & hit, write: cache_we=1.
  - WB_MODE=1: set_dirty=1, stall=0, stay.
  - WB_MODE=0: stall=1, go WT_WRITE.
- IDLE, req & ~hit: stall=1, miss_cnt++.
  - WB_MODE=1 & dirty: go WRITE_BACK.
  - Otherwise: go FILL.
- WRITE_BACK: mem_req=1, mem_we=1, writeback=1, stall=1.
  - On mem_ack: word_idx++.
  - On mem_ack at word_idx==WORDS_PER_LINE-1: word_idx wraps to 0, clr_dirty=1, go FILL.
  - No ack: hold state and word_idx indefinitely (no timeout).
- FILL: mem_req=1, mem_we=0, stall=1, load=mem_ack.
  - Each ack advances word_idx.
  - Ack on the last beat: word_idx=0, set_valid=1, clr_dirty=1, go RETRY.
- RETRY: stall=1, one cycle. Go IDLE and set after_retry=1. The held CPU request is re-evaluated in IDLE and now hits.
- WT_WRITE: mem_req=1, mem_we=1, word_idx=0, stall=~mem_ack. On ack go IDLE. The CPU advances in the ack cycle, so the store is never replayed.
- hit_cnt++ on IDLE & req & hit only when after_retry=0. after_retry clears on any IDLE cycle.
- Both counters saturate at all-ones: no wrap.
- A request arriving in any non-IDLE state is not sampled.
- stall, mem_req, mem_we, writeback and word_idx are Moore in the transfer states. stall, cache_we, set_dirty and load are combinational (Mealy) in IDLE/WT_WRITE/FILL.
- Latency:
  - Read hit: 0 stall cycles.
  - Clean miss: WORDS_PER_LINE acks + 1 RETRY cycle + 1 IDLE stall cycle.
  - Dirty miss: an additional WORDS_PER_LINE acks.

Decomposition:
- Package dcache_pkg holds:
  - the state enum typedef (IDLE, WRITE_BACK, FILL, RETRY, WT_WRITE);
  - localparams POLICY_WT=0 and POLICY_WB=1.
- Sub-module sat_counter #(W), instantiated twice for hit_cnt and miss_cnt. Ports: CLK, RST_N, inc, count.

Test Plan:
- WB_MODE=1, WORDS_PER_LINE=4, read hit -> stall=0 same cycle, hit_cnt 0->1, no mem_req.
- Read miss with dirty=1, ack every cycle -> 4 beats mem_we=1 with word_idx 0..3, clr_dirty pulse, then 4 beats load=1 with word_idx 0..3, set_valid pulse, RETRY, hit. Result: miss_cnt=1, hit_cnt=0.
- Clean miss, ack asserted every 3rd cycle -> word_idx holds between acks, exactly 4 load pulses, stall continuous until the IDLE hit.
- WB_MODE=0, write hit -> cache_we=1, WT_WRITE holds stall until ack (delay 5 cycles), then stall=0 on the ack cycle and no second cache_we.
- RST_N low during FILL beat 2 -> mem_req=0 and stall=0 asynchronously, word_idx=0, counters=0, no set_valid pulse.
- CNT_W=2, 5 read hits -> hit_cnt sequence 1,2,3,3,3.
